// File: rtl/b10_vote_fsm.sv
// b10_vote_fsm: push-button vote collector with RTS/CTS word exchange
// and a self-test path that drives the send path.
module b10_vote_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       r_button,
  input  logic       g_button,
  input  logic       key,
  input  logic       start,
  input  logic       test,
  input  logic       rts,
  input  logic       rtr,
  input  logic [3:0] v_in,
  input  logic       __obs,
  output logic       cts,
  output logic       ctr,
  output logic [3:0] v_out
);

  typedef enum logic [3:0] {
    S_STARTUP  = 4'd0,
    S_STANDBY  = 4'd1,
    S_GET_IN   = 4'd2,
    S_START_TX = 4'd3,
    S_SEND     = 4'd4,
    S_TX_2_RX  = 4'd5,
    S_RECEIVE  = 4'd6,
    S_RX_2_TX  = 4'd7,
    S_END_TX   = 4'd8,
    S_TEST_1   = 4'd9,
    S_TEST_2   = 4'd10
  } state_e;

  localparam logic [3:0] EndWord  = 4'b0110;
  localparam logic [3:0] TestKey  = 4'b1111;
  localparam logic [3:0] TestSign = 4'b1000;

  state_e     state_q, state_d;
  logic [3:0] voto_q, voto_d;
  logic [3:0] sign_q, sign_d;
  logic       last_g_q, last_g_d;
  logic       last_r_q, last_r_d;
  logic       cts_q, cts_d;
  logic       ctr_q, ctr_d;
  logic [3:0] v_out_q, v_out_d;

  // observation strobe has no functional effect
  logic unused_obs;
  assign unused_obs = __obs;

  // state and datapath registers, async active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_STARTUP;
      voto_q   <= '0;
      sign_q   <= '0;
      last_g_q <= 1'b0;
      last_r_q <= 1'b0;
      cts_q    <= 1'b0;
      ctr_q    <= 1'b0;
      v_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      voto_q   <= voto_d;
      sign_q   <= sign_d;
      last_g_q <= last_g_d;
      last_r_q <= last_r_d;
      cts_q    <= cts_d;
      ctr_q    <= ctr_d;
      v_out_q  <= v_out_d;
    end
  end

  // next-state and next-register values; everything holds by default
  always_comb begin
    state_d  = state_q;
    voto_d   = voto_q;
    sign_d   = sign_q;
    last_g_d = last_g_q;
    last_r_d = last_r_q;
    cts_d    = cts_q;
    ctr_d    = ctr_q;
    v_out_d  = v_out_q;
    case (state_q)
      S_STARTUP: begin
        voto_d = '0;
        cts_d  = 1'b0;
        ctr_d  = 1'b0;
        if (!test) begin
          sign_d  = '0;
          state_d = S_TEST_1;
        end else begin
          state_d = S_STANDBY;
        end
      end
      S_STANDBY: begin
        cts_d = rtr;
        if (start) begin
          voto_d  = '0;
          state_d = S_GET_IN;
        end
      end
      S_GET_IN: begin
        if (!start) begin
          state_d = S_START_TX;
        end else if (key) begin
          voto_d[0] = 1'b1;
          if (g_button && !last_g_q)
            voto_d[1] = ~voto_q[1];
          if (r_button && !last_r_q)
            voto_d[2] = ~voto_q[2];
          last_g_d = g_button;
          last_r_d = r_button;
        end else begin
          voto_d = '0;
        end
      end
      S_START_TX: begin
        voto_d[3] = voto_q[1] ^ voto_q[2];
        voto_d[0] = 1'b0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (rtr) begin
          v_out_d = voto_q;
          cts_d   = 1'b1;
          if (voto_q == EndWord)
            state_d = S_END_TX;
          else
            state_d = S_TX_2_RX;
        end
      end
      S_TX_2_RX: begin
        if (!rtr) begin
          cts_d   = 1'b0;
          state_d = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (rts) begin
          voto_d  = v_in;
          ctr_d   = 1'b1;
          state_d = S_RX_2_TX;
        end
      end
      S_RX_2_TX: begin
        if (!rts) begin
          ctr_d   = 1'b0;
          state_d = S_SEND;
        end
      end
      S_END_TX: begin
        if (!rtr) begin
          cts_d   = 1'b0;
          state_d = S_STANDBY;
        end
      end
      S_TEST_1: begin
        voto_d = v_in;
        sign_d = TestSign;
        if (v_in == TestKey)
          state_d = S_TEST_2;
      end
      S_TEST_2: begin
        voto_d  = sign_q;
        state_d = S_SEND;
      end
      default: state_d = S_STARTUP;
    endcase
  end

  assign cts   = cts_q;
  assign ctr   = ctr_q;
  assign v_out = v_out_q;

endmodule

// File: tb/tb_b10_vote_fsm.sv
// tb_b10_vote_fsm: directed scenarios for the vote/handshake FSM,
// checking {cts, ctr, v_out} against hand-derived values.
module tb_b10_vote_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       r_button, g_button, key, start, test;
  logic       rts, rtr;
  logic [3:0] v_in;
  logic       obs_strobe;
  logic       cts, ctr;
  logic [3:0] v_out;

  int errors = 0;
  int checks = 0;

  b10_vote_fsm dut (
    .clock    (clock),
    .reset    (reset),
    .r_button (r_button),
    .g_button (g_button),
    .key      (key),
    .start    (start),
    .test     (test),
    .rts      (rts),
    .rtr      (rtr),
    .v_in     (v_in),
    .__obs    (obs_strobe),
    .cts      (cts),
    .ctr      (ctr),
    .v_out    (v_out)
  );

  always #5 clock = ~clock;

  // toggle the observation strobe freely; it must not matter
  always @(negedge clock) obs_strobe = $urandom_range(0, 1);

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    r_button = 1; g_button = 1; key = 1; start = 1;
    test = 1; rts = 1; rtr = 1; v_in = 4'b1111;
    obs_strobe = 0;
    #3;
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_async: got %b want 000000", {cts, ctr, v_out});
    end
    step(2);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_held: got %b want 000000", {cts, ctr, v_out});
    end
    r_button = 0; g_button = 0; key = 0; start = 0;
    rts = 0; rtr = 0; v_in = 4'b0000;
    reset = 1'b1;
    step(2);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL standby_idle: got %b want 000000", {cts, ctr, v_out});
    end
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0000) begin
      errors++;
      $display("FAIL standby_cts_follow: got %b want 100000", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL standby_cts_drop: got %b want 000000", {cts, ctr, v_out});
    end
  endtask

  task automatic test_vote;
    start = 1; key = 1;
    step(1);
    g_button = 1;
    step(3);
    start = 0; g_button = 0;
    step(2);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL send_wait: got %b want 000000", {cts, ctr, v_out});
    end
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_1010) begin
      errors++;
      $display("FAIL send_vote: got %b want 101010", {cts, ctr, v_out});
    end
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_1010) begin
      errors++;
      $display("FAIL tx2rx_hold: got %b want 101010", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_1010) begin
      errors++;
      $display("FAIL tx2rx_done: got %b want 001010", {cts, ctr, v_out});
    end
  endtask

  task automatic test_receive;
    v_in = 4'b0110;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_1010) begin
      errors++;
      $display("FAIL receive_wait: got %b want 001010", {cts, ctr, v_out});
    end
    rts = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b01_1010) begin
      errors++;
      $display("FAIL receive_ctr: got %b want 011010", {cts, ctr, v_out});
    end
    rts = 0;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_1010) begin
      errors++;
      $display("FAIL rx2tx_done: got %b want 001010", {cts, ctr, v_out});
    end
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0110) begin
      errors++;
      $display("FAIL send_end_word: got %b want 100110", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0110) begin
      errors++;
      $display("FAIL end_tx_done: got %b want 000110", {cts, ctr, v_out});
    end
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0110) begin
      errors++;
      $display("FAIL back_in_standby: got %b want 100110", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
  endtask

  task automatic test_key_cancel;
    start = 1; key = 1; g_button = 0; r_button = 0;
    step(2);
    g_button = 1; r_button = 1;
    step(1);
    key = 0;
    step(1);
    start = 0; g_button = 0; r_button = 0;
    step(2);
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0000) begin
      errors++;
      $display("FAIL key_cancel: got %b want 100000", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
  endtask

  task automatic test_rx_reset;
    v_in = 4'b0101; rts = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b01_0000) begin
      errors++;
      $display("FAIL rx_before_abort: got %b want 010000", {cts, ctr, v_out});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL abort_async: got %b want 000000", {cts, ctr, v_out});
    end
    rts = 0; test = 0; v_in = 4'b0011;
    step(1);
    reset = 1'b1;
  endtask

  task automatic test_selftest;
    step(2);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL test1_wait: got %b want 000000", {cts, ctr, v_out});
    end
    v_in = 4'b1111;
    step(2);
    v_in = 4'b0000;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL selftest_send_wait: got %b want 000000", {cts, ctr, v_out});
    end
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_1000) begin
      errors++;
      $display("FAIL selftest_send: got %b want 101000", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_1000) begin
      errors++;
      $display("FAIL selftest_tx2rx: got %b want 001000", {cts, ctr, v_out});
    end
  endtask

  task automatic test_hold_once;
    test = 1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cts, ctr, v_out} !== 6'b00_0000) begin
      errors++;
      $display("FAIL reset_clears_vout: got %b want 000000", {cts, ctr, v_out});
    end
    step(1);
    reset = 1'b1;
    step(1);
    start = 1; key = 1; g_button = 0; r_button = 0;
    step(1);
    g_button = 1; r_button = 1;
    step(2);
    start = 0; g_button = 0; r_button = 0;
    step(2);
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0110) begin
      errors++;
      $display("FAIL hold_toggle_once: got %b want 100110", {cts, ctr, v_out});
    end
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0110) begin
      errors++;
      $display("FAIL end_tx_hold: got %b want 100110", {cts, ctr, v_out});
    end
    rtr = 0;
    step(1);
    rtr = 1;
    step(1);
    checks++;
    if ({cts, ctr, v_out} !== 6'b10_0110) begin
      errors++;
      $display("FAIL end_to_standby: got %b want 100110", {cts, ctr, v_out});
    end
  endtask

  initial begin
    test_reset();
    test_vote();
    test_receive();
    test_key_cancel();
    test_rx_reset();
    test_selftest();
    test_hold_once();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
